// File: rtl/t05_cb_writer.sv
// Codebook writer: captures finished codewords and stores each as a header word
// plus up to four path words in SRAM, then writes a trailer with the codeword count.
module t05_cb_writer #(
    parameter logic [31:0] BASE_ADDR    = 32'h3300_0000,
    parameter int          STRIDE_BYTES = 20
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         en,
    input  logic         char_found,
    input  logic [7:0]   char_index,
    input  logic [127:0] char_path,
    input  logic [6:0]   code_len,
    input  logic         tree_done,
    input  logic         wr_ack,
    output logic         wr_req,
    output logic [31:0]  wr_addr,
    output logic [31:0]  wr_data,
    output logic         busy,
    output logic [8:0]   cw_count,
    output logic         overflow,
    output logic         done,
    output logic [2:0]   state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_PATH   = 3'd2,
        S_COMMIT = 3'd3,
        S_TRLR   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [31:0] STRIDE    = 32'(STRIDE_BYTES);
    localparam logic [31:0] TRLR_ADDR = BASE_ADDR + 32'd256 * STRIDE;

    state_t         state;
    logic           cf_q;
    logic [7:0]     idx_q;
    logic [127:0]   path_q;
    logic [6:0]     len_q;
    logic [1:0]     k_q;

    logic           rise;
    logic [7:0]     len_rnd;
    logic [2:0]     n_path;
    logic [2:0]     k_next;
    logic [31:0]    entry_addr;
    logic [31:0]    path_word;

    assign state_dbg  = 3'(state);
    assign rise       = char_found & ~cf_q;
    assign len_rnd    = {1'b0, len_q} + 8'd31;
    assign n_path     = len_rnd[7:5];
    assign k_next     = {1'b0, k_q} + 3'd1;
    assign entry_addr = BASE_ADDR + 32'(idx_q) * STRIDE;
    assign path_word  = path_q[{k_q, 5'b00000} +: 32];

    // Each write state raises wr_req while idle and retires the word on the
    // first acked cycle, so wr_req is always low for at least one cycle between words.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= S_IDLE;
            cf_q     <= 1'b0;
            idx_q    <= 8'h0;
            path_q   <= 128'h0;
            len_q    <= 7'h0;
            k_q      <= 2'h0;
            wr_req   <= 1'b0;
            wr_addr  <= 32'h0;
            wr_data  <= 32'h0;
            busy     <= 1'b0;
            cw_count <= 9'h0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else if (en) begin
            cf_q <= char_found;
            if (rise && state != S_IDLE && state != S_DONE)
                overflow <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (rise) begin
                        idx_q  <= char_index;
                        path_q <= char_path;
                        len_q  <= code_len;
                        busy   <= 1'b1;
                        state  <= S_HDR;
                    end else if (tree_done) begin
                        busy  <= 1'b1;
                        state <= S_TRLR;
                    end
                end
                S_HDR: begin
                    if (!wr_req) begin
                        wr_req  <= 1'b1;
                        wr_addr <= entry_addr;
                        wr_data <= {1'b1, 16'h0, len_q, idx_q};
                    end else if (wr_ack) begin
                        wr_req <= 1'b0;
                        k_q    <= 2'h0;
                        state  <= (n_path != 3'd0) ? S_PATH : S_COMMIT;
                    end
                end
                S_PATH: begin
                    if (!wr_req) begin
                        wr_req  <= 1'b1;
                        wr_addr <= entry_addr + 32'd4 + {28'h0, k_q, 2'b00};
                        wr_data <= path_word;
                    end else if (wr_ack) begin
                        wr_req <= 1'b0;
                        if (k_next < n_path)
                            k_q <= k_next[1:0];
                        else
                            state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    if (cw_count != 9'd256)
                        cw_count <= cw_count + 9'd1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_TRLR: begin
                    if (!wr_req) begin
                        wr_req  <= 1'b1;
                        wr_addr <= TRLR_ADDR;
                        wr_data <= {23'h0, cw_count};
                    end else if (wr_ack) begin
                        wr_req <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_t05_cb_writer.sv
// Directed bench for t05_cb_writer: each task drives one scenario and checks
// SRAM write addresses/data, counters and sticky flags against hand-computed values.
module tb_t05_cb_writer;

    logic         clk;
    logic         nrst;
    logic         en;
    logic         char_found;
    logic [7:0]   char_index;
    logic [127:0] char_path;
    logic [6:0]   code_len;
    logic         tree_done;
    logic         wr_ack;
    logic         wr_req;
    logic [31:0]  wr_addr;
    logic [31:0]  wr_data;
    logic         busy;
    logic [8:0]   cw_count;
    logic         overflow;
    logic         done;
    logic [2:0]   state_dbg;

    int checks;
    int errors;

    t05_cb_writer dut (
        .clk        (clk),
        .nrst       (nrst),
        .en         (en),
        .char_found (char_found),
        .char_index (char_index),
        .char_path  (char_path),
        .code_len   (code_len),
        .tree_done  (tree_done),
        .wr_ack     (wr_ack),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .cw_count   (cw_count),
        .overflow   (overflow),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        nrst       = 1'b0;
        en         = 1'b1;
        char_found = 1'b0;
        char_index = 8'h0;
        char_path  = 128'h0;
        code_len   = 7'h0;
        tree_done  = 1'b0;
        wr_ack     = 1'b0;
        step();
        step();
        nrst = 1'b1;
        step();
    endtask

    // Rising edge of char_found with the given codeword, then release.
    task automatic send_cw(input logic [7:0] idx, input logic [6:0] len,
                           input logic [127:0] path);
        char_index = idx;
        code_len   = len;
        char_path  = path;
        char_found = 1'b1;
        step();
        step();
        char_found = 1'b0;
    endtask

    // Waits for a request, holds off the ack for 'delay' cycles, then acks.
    // ok=0 on timeout, unstable addr/data, or wr_req not dropping after ack.
    task automatic do_write(input int delay, output logic [31:0] a,
                            output logic [31:0] d, output bit ok);
        int n;
        ok = 1'b1;
        n  = 0;
        a  = 32'hx;
        d  = 32'hx;
        while (wr_req !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (wr_req !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        a = wr_addr;
        d = wr_data;
        repeat (delay) begin
            step();
            if (wr_req !== 1'b1 || wr_addr !== a || wr_data !== d) ok = 1'b0;
        end
        wr_ack = 1'b1;
        step();
        wr_ack = 1'b0;
        if (wr_req !== 1'b0) ok = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        #2;
        checks++;
        if ({wr_req, wr_addr, wr_data, busy, cw_count, overflow, done} !== 76'h0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%0b addr=%h data=%h busy=%0b cnt=%0d ovf=%0b done=%0b, want all 0",
                     wr_req, wr_addr, wr_data, busy, cw_count, overflow, done);
        end
        apply_reset();
    endtask

    task automatic test_basic();
        logic [31:0] a, d;
        bit ok;
        char_index = 8'h41;
        code_len   = 7'd3;
        char_path  = 128'h5;
        char_found = 1'b1;
        step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %0b want 1", busy);
        end
        step();
        char_found = 1'b0;
        do_write(0, a, d, ok);
        checks++;
        if (!ok || a !== 32'h3300_0514 || d !== 32'h8000_0341) begin
            errors++;
            $display("FAIL basic_hdr: got ok=%0b %h/%h want 33000514/80000341", ok, a, d);
        end
        do_write(1, a, d, ok);
        checks++;
        if (!ok || a !== 32'h3300_0518 || d !== 32'h0000_0005) begin
            errors++;
            $display("FAIL basic_path: got ok=%0b %h/%h want 33000518/00000005", ok, a, d);
        end
        step();
        checks++;
        if (cw_count !== 9'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_commit: got cnt=%0d busy=%0b want 1/0", cw_count, busy);
        end
    endtask

    task automatic test_long();
        logic [31:0] a, d;
        bit ok;
        logic [31:0] exp_d [5];
        exp_d[0] = 32'h8000_7F02;
        exp_d[1] = 32'hFFFF_FFFF;
        exp_d[2] = 32'hFFFF_FFFF;
        exp_d[3] = 32'hFFFF_FFFF;
        exp_d[4] = 32'h7FFF_FFFF;
        send_cw(8'h02, 7'd127, {1'b0, {127{1'b1}}});
        for (int i = 0; i < 5; i++) begin
            do_write(3, a, d, ok);
            checks++;
            if (!ok || a !== 32'h3300_0028 + 32'(4 * i) || d !== exp_d[i]) begin
                errors++;
                $display("FAIL long_word%0d: got ok=%0b %h/%h want %h/%h",
                         i, ok, a, d, 32'h3300_0028 + 32'(4 * i), exp_d[i]);
            end
        end
        step();
        checks++;
        if (cw_count !== 9'd2) begin
            errors++;
            $display("FAIL long_count: got %0d want 2", cw_count);
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] a, d;
        bit ok;
        bit extra;
        // len=32: exactly one path word, upper path bits never written
        send_cw(8'h10, 7'd32, {96'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF, 32'hDEAD_BEEF});
        do_write(0, a, d, ok);
        checks++;
        if (!ok || a !== 32'h3300_0140 || d !== 32'h8000_2010) begin
            errors++;
            $display("FAIL len32_hdr: got ok=%0b %h/%h want 33000140/80002010", ok, a, d);
        end
        do_write(0, a, d, ok);
        checks++;
        if (!ok || a !== 32'h3300_0144 || d !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL len32_path: got ok=%0b %h/%h want 33000144/deadbeef", ok, a, d);
        end
        extra = 1'b0;
        repeat (6) begin
            step();
            if (wr_req !== 1'b0) extra = 1'b1;
        end
        checks++;
        if (extra || cw_count !== 9'd3) begin
            errors++;
            $display("FAIL len32_end: got extra_req=%0b cnt=%0d want 0/3", extra, cw_count);
        end
        // len=33: two path words
        send_cw(8'h11, 7'd33, {64'h0, 32'h0000_0001, 32'hCAFE_F00D});
        do_write(0, a, d, ok);
        checks++;
        if (!ok || a !== 32'h3300_0154 || d !== 32'h8000_2111) begin
            errors++;
            $display("FAIL len33_hdr: got ok=%0b %h/%h want 33000154/80002111", ok, a, d);
        end
        do_write(0, a, d, ok);
        checks++;
        if (!ok || a !== 32'h3300_0158 || d !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL len33_p0: got ok=%0b %h/%h want 33000158/cafef00d", ok, a, d);
        end
        do_write(0, a, d, ok);
        checks++;
        if (!ok || a !== 32'h3300_015C || d !== 32'h0000_0001) begin
            errors++;
            $display("FAIL len33_p1: got ok=%0b %h/%h want 3300015c/00000001", ok, a, d);
        end
        step();
        // len=0: header only, highest index
        send_cw(8'hFF, 7'd0, 128'h1234);
        do_write(0, a, d, ok);
        checks++;
        if (!ok || a !== 32'h3300_13EC || d !== 32'h8000_00FF) begin
            errors++;
            $display("FAIL len0_hdr: got ok=%0b %h/%h want 330013ec/800000ff", ok, a, d);
        end
        extra = 1'b0;
        repeat (6) begin
            step();
            if (wr_req !== 1'b0) extra = 1'b1;
        end
        checks++;
        if (extra || cw_count !== 9'd5) begin
            errors++;
            $display("FAIL len0_end: got extra_req=%0b cnt=%0d want 0/5", extra, cw_count);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] a, d;
        bit ok;
        bit extra;
        apply_reset();
        send_cw(8'h01, 7'd40, {64'h0, 32'h2222_2222, 32'h1111_1111});
        do_write(0, a, d, ok);
        checks++;
        if (!ok || a !== 32'h3300_0014 || d !== 32'h8000_2801) begin
            errors++;
            $display("FAIL ovf_hdr: got ok=%0b %h/%h want 33000014/80002801", ok, a, d);
        end
        send_cw(8'h55, 7'd5, 128'h1F);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: got %0b want 1", overflow);
        end
        do_write(0, a, d, ok);
        checks++;
        if (!ok || a !== 32'h3300_0018 || d !== 32'h1111_1111) begin
            errors++;
            $display("FAIL ovf_p0: got ok=%0b %h/%h want 33000018/11111111", ok, a, d);
        end
        do_write(0, a, d, ok);
        checks++;
        if (!ok || a !== 32'h3300_001C || d !== 32'h2222_2222) begin
            errors++;
            $display("FAIL ovf_p1: got ok=%0b %h/%h want 3300001c/22222222", ok, a, d);
        end
        extra = 1'b0;
        repeat (6) begin
            step();
            if (wr_req !== 1'b0) extra = 1'b1;
        end
        checks++;
        if (extra || cw_count !== 9'd1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_end: got extra_req=%0b cnt=%0d ovf=%0b want 0/1/1",
                     extra, cw_count, overflow);
        end
    endtask

    task automatic test_trailer();
        logic [31:0] a, d;
        bit ok;
        bit extra;
        apply_reset();
        for (int i = 1; i <= 3; i++) begin
            send_cw(8'(i), 7'd0, 128'h0);
            do_write(0, a, d, ok);
            checks++;
            if (!ok || a !== 32'h3300_0000 + 32'(20 * i) || d !== 32'h8000_0000 + 32'(i)) begin
                errors++;
                $display("FAIL trl_entry%0d: got ok=%0b %h/%h", i, ok, a, d);
            end
            step();
        end
        tree_done = 1'b1;
        do_write(2, a, d, ok);
        checks++;
        if (!ok || a !== 32'h3300_1400 || d !== 32'h0000_0003 || done !== 1'b1) begin
            errors++;
            $display("FAIL trl_write: got ok=%0b %h/%h done=%0b want 33001400/00000003/1",
                     ok, a, d, done);
        end
        tree_done = 1'b0;
        send_cw(8'h09, 7'd8, 128'hFF);
        extra = 1'b0;
        repeat (10) begin
            step();
            if (wr_req !== 1'b0) extra = 1'b1;
        end
        checks++;
        if (extra || done !== 1'b1 || overflow !== 1'b0 || cw_count !== 9'd3) begin
            errors++;
            $display("FAIL trl_after: got extra_req=%0b done=%0b ovf=%0b cnt=%0d want 0/1/0/3",
                     extra, done, overflow, cw_count);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] a, d;
        bit ok;
        apply_reset();
        char_index = 8'h07;
        code_len   = 7'd0;
        char_path  = 128'h0;
        char_found = 1'b1;
        tree_done  = 1'b1;
        step();
        char_found = 1'b0;
        do_write(0, a, d, ok);
        checks++;
        if (!ok || a !== 32'h3300_008C || d !== 32'h8000_0007) begin
            errors++;
            $display("FAIL sim_hdr: got ok=%0b %h/%h want 3300008c/80000007", ok, a, d);
        end
        do_write(0, a, d, ok);
        checks++;
        if (!ok || a !== 32'h3300_1400 || d !== 32'h0000_0001) begin
            errors++;
            $display("FAIL sim_trl: got ok=%0b %h/%h want 33001400/00000001", ok, a, d);
        end
        tree_done = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, d;
        bit ok;
        int n;
        apply_reset();
        send_cw(8'h04, 7'd64, {64'h0, 64'h1234_5678_9ABC_DEF0});
        do_write(0, a, d, ok);
        n = 0;
        while (wr_req !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (wr_req !== 1'b1 || wr_addr !== 32'h3300_0054) begin
            errors++;
            $display("FAIL rst_mid_pre: got req=%0b addr=%h want 1/33000054", wr_req, wr_addr);
        end
        #2;
        nrst = 1'b0;
        #1;
        checks++;
        if ({wr_req, wr_addr, wr_data, busy, cw_count, overflow, done} !== 76'h0) begin
            errors++;
            $display("FAIL rst_mid: got req=%0b addr=%h data=%h busy=%0b cnt=%0d want all 0",
                     wr_req, wr_addr, wr_data, busy, cw_count);
        end
        step();
        nrst = 1'b1;
        step();
    endtask

    task automatic test_enable_hold();
        logic [31:0] a, d;
        bit ok;
        bit moved;
        int n;
        apply_reset();
        send_cw(8'h05, 7'd0, 128'h0);
        n = 0;
        while (wr_req !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        en     = 1'b0;
        wr_ack = 1'b1;
        moved  = (wr_req !== 1'b1);
        repeat (10) begin
            step();
            if (wr_req !== 1'b1 || wr_addr !== 32'h3300_0064 || cw_count !== 9'd0) moved = 1'b1;
        end
        wr_ack = 1'b0;
        checks++;
        if (moved) begin
            errors++;
            $display("FAIL en_hold: got req=%0b addr=%h cnt=%0d want 1/33000064/0",
                     wr_req, wr_addr, cw_count);
        end
        en = 1'b1;
        do_write(0, a, d, ok);
        checks++;
        if (!ok || a !== 32'h3300_0064 || d !== 32'h8000_0005) begin
            errors++;
            $display("FAIL en_resume: got ok=%0b %h/%h want 33000064/80000005", ok, a, d);
        end
        step();
        checks++;
        if (cw_count !== 9'd1) begin
            errors++;
            $display("FAIL en_count: got %0d want 1", cw_count);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        en         = 1'b1;
        char_found = 1'b0;
        char_index = 8'h0;
        char_path  = 128'h0;
        code_len   = 7'h0;
        tree_done  = 1'b0;
        wr_ack     = 1'b0;
        test_reset();
        test_basic();
        test_long();
        test_boundaries();
        test_overflow();
        test_trailer();
        test_simultaneous();
        test_reset_mid();
        test_enable_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
